// File: rtl/cmd_burst_fifo.sv
// Ordered command/write-data FIFO for the DDR command path. Write bursts can be
// held back from the pop side until every beat is stored (packet mode).
module cmd_burst_fifo #(
  parameter int TYPE_WIDTH  = 2,
  parameter int ADDR_WIDTH  = 27,
  parameter int BRST_WIDTH  = 6,
  parameter int DATA_WIDTH  = 128,
  parameter int MASK_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 1,
  parameter int AFULL_LVL   = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    io_push_valid,
  output logic                    io_push_ready,
  input  logic [TYPE_WIDTH-1:0]   io_push_cmd_type,
  input  logic [ADDR_WIDTH-1:0]   io_push_addr,
  input  logic [BRST_WIDTH-1:0]   io_push_burst_cnt,
  input  logic [DATA_WIDTH-1:0]   io_push_wt_data,
  input  logic [MASK_WIDTH-1:0]   io_push_wt_mask,
  output logic                    io_pop_valid,
  input  logic                    io_pop_ready,
  output logic [TYPE_WIDTH-1:0]   io_pop_cmd_type,
  output logic [ADDR_WIDTH-1:0]   io_pop_addr,
  output logic [BRST_WIDTH-1:0]   io_pop_burst_cnt,
  output logic [DATA_WIDTH-1:0]   io_pop_wt_data,
  output logic [MASK_WIDTH-1:0]   io_pop_wt_mask,
  output logic                    io_pop_last,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic                    burst_pending,
  output logic                    err_burst
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [TYPE_WIDTH-1:0] T_IDE = '0;
  localparam logic [TYPE_WIDTH-1:0] T_WT  = TYPE_WIDTH'(2);
  localparam logic [PW:0]           PTR_ONE  = (PW+1)'(1);
  localparam logic [BRST_WIDTH-1:0] BEAT_ONE = BRST_WIDTH'(1);

  typedef enum logic {P_IDLE, P_BURST} pstate_t;

  // Handshake: a beat moves on a side only in a cycle where valid && ready.
  logic [TYPE_WIDTH-1:0] mem_type [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [BRST_WIDTH-1:0] mem_brst [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [MASK_WIDTH-1:0] mem_mask [DEPTH];
  logic                  mem_last [DEPTH];

  pstate_t               state;
  logic [PW:0]           wr_ptr, cmt_ptr, rd_ptr;
  logic [BRST_WIDTH-1:0] blen, beat;
  logic                  per_beat;

  logic full, has_data, push_fire, store, pop_fire;
  logic is_wt, start_burst, oversize, st_last, commit;
  logic [PW-1:0] wr_idx, rd_idx;

  assign wr_idx   = wr_ptr[PW-1:0];
  assign rd_idx   = rd_ptr[PW-1:0];
  assign full     = (wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]});
  assign has_data = (cmt_ptr != rd_ptr);

  assign io_push_ready = !rst && !full;
  assign io_pop_valid  = !rst && has_data;
  assign push_fire     = io_push_valid && io_push_ready;
  assign store         = push_fire && (io_push_cmd_type != T_IDE);
  assign pop_fire      = io_pop_valid && io_pop_ready;

  // A burst that can never fit is released beat by beat so the FIFO cannot lock up.
  always_comb begin
    is_wt       = (io_push_cmd_type == T_WT);
    start_burst = (state == P_IDLE) && is_wt && (io_push_burst_cnt != '0);
    oversize    = start_burst && (32'(io_push_burst_cnt) >= 32'(DEPTH));
    st_last     = (state == P_IDLE) ? !start_burst : (!is_wt || (beat == blen));
    commit      = store && (st_last || per_beat || oversize || (PACKET_MODE == 0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= P_IDLE;
      wr_ptr    <= '0;
      cmt_ptr   <= '0;
      rd_ptr    <= '0;
      blen      <= '0;
      beat      <= '0;
      per_beat  <= 1'b0;
      err_burst <= 1'b0;
    end else begin
      if (pop_fire) rd_ptr <= rd_ptr + PTR_ONE;
      if (store) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (commit) cmt_ptr <= wr_ptr + PTR_ONE;
        case (state)
          P_IDLE: begin
            if (start_burst) begin
              state    <= P_BURST;
              blen     <= io_push_burst_cnt;
              beat     <= BEAT_ONE;
              per_beat <= oversize;
              if (oversize) err_burst <= 1'b1;
            end
          end
          P_BURST: begin
            if (st_last) begin
              state    <= P_IDLE;
              per_beat <= 1'b0;
              if (!is_wt) err_burst <= 1'b1;
            end else begin
              beat <= beat + BEAT_ONE;
            end
          end
          default: state <= P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_type[wr_idx] <= io_push_cmd_type;
      mem_addr[wr_idx] <= io_push_addr;
      mem_brst[wr_idx] <= io_push_burst_cnt;
      mem_data[wr_idx] <= io_push_wt_data;
      mem_mask[wr_idx] <= io_push_wt_mask;
      mem_last[wr_idx] <= st_last;
    end
  end

  assign io_pop_cmd_type  = mem_type[rd_idx];
  assign io_pop_addr      = mem_addr[rd_idx];
  assign io_pop_burst_cnt = mem_brst[rd_idx];
  assign io_pop_wt_data   = mem_data[rd_idx];
  assign io_pop_wt_mask   = mem_mask[rd_idx];
  assign io_pop_last      = io_pop_valid && mem_last[rd_idx];

  assign level         = wr_ptr - rd_ptr;
  assign almost_full   = (32'(level) >= 32'(AFULL_LVL));
  assign burst_pending = (state == P_BURST);

endmodule

// File: tb/tb_cmd_burst_fifo.sv
// Bench for cmd_burst_fifo: directed scenarios plus random traffic, each cycle
// compared against a queue-based model of committed and pending beats.
module tb_cmd_burst_fifo;

  localparam int DEPTH       = 16;
  localparam int PACKET_MODE = 1;
  localparam logic [1:0] IDE = 2'd0, CMD = 2'd1, WT = 2'd2, RD = 2'd3;

  typedef struct packed {
    logic [1:0]   t;
    logic [26:0]  a;
    logic [5:0]   b;
    logic [127:0] d;
    logic [15:0]  m;
    logic         last;
  } beat_t;
  localparam int W = $bits(beat_t);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         io_push_valid = 1'b0;
  logic         io_push_ready;
  logic [1:0]   io_push_cmd_type = '0;
  logic [26:0]  io_push_addr = '0;
  logic [5:0]   io_push_burst_cnt = '0;
  logic [127:0] io_push_wt_data = '0;
  logic [15:0]  io_push_wt_mask = '0;
  logic         io_pop_valid;
  logic         io_pop_ready = 1'b0;
  logic [1:0]   io_pop_cmd_type;
  logic [26:0]  io_pop_addr;
  logic [5:0]   io_pop_burst_cnt;
  logic [127:0] io_pop_wt_data;
  logic [15:0]  io_pop_wt_mask;
  logic         io_pop_last;
  logic [4:0]   level;
  logic         almost_full;
  logic         burst_pending;
  logic         err_burst;

  cmd_burst_fifo #(.DEPTH(DEPTH), .PACKET_MODE(PACKET_MODE)) dut (
    .clk(clk), .rst(rst),
    .io_push_valid(io_push_valid), .io_push_ready(io_push_ready),
    .io_push_cmd_type(io_push_cmd_type), .io_push_addr(io_push_addr),
    .io_push_burst_cnt(io_push_burst_cnt), .io_push_wt_data(io_push_wt_data),
    .io_push_wt_mask(io_push_wt_mask),
    .io_pop_valid(io_pop_valid), .io_pop_ready(io_pop_ready),
    .io_pop_cmd_type(io_pop_cmd_type), .io_pop_addr(io_pop_addr),
    .io_pop_burst_cnt(io_pop_burst_cnt), .io_pop_wt_data(io_pop_wt_data),
    .io_pop_wt_mask(io_pop_wt_mask), .io_pop_last(io_pop_last),
    .level(level), .almost_full(almost_full),
    .burst_pending(burst_pending), .err_burst(err_burst)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: exp_q holds beats the consumer may see, pend_q stored but unreleased
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_q[$];
  bit m_in_burst, m_per_beat, m_err;
  int m_left;
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] t, input logic [26:0] a, input logic [5:0] b,
                               input logic [127:0] d, input logic [15:0] m);
    beat_t x;
    x.t = t; x.a = a; x.b = b; x.d = d; x.m = m; x.last = 1'b0;
    return x;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    pend_q.delete();
    m_in_burst = 0; m_per_beat = 0; m_err = 0; m_left = 0;
  endfunction

  function automatic void model_put(input beat_t x, input bit cmt);
    if (cmt || PACKET_MODE == 0 || m_per_beat) begin
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      exp_q.push_back(x);
    end else begin
      pend_q.push_back(x);
    end
  endfunction

  function automatic void model_store(input beat_t x);
    if (!m_in_burst) begin
      if (x.t == WT && x.b != 0) begin
        m_in_burst = 1;
        m_left = int'(x.b);
        m_per_beat = (int'(x.b) + 1 > DEPTH);
        if (m_per_beat) m_err = 1;
        x.last = 1'b0;
        model_put(x, 0);
      end else begin
        x.last = 1'b1;
        model_put(x, 1);
      end
    end else if (x.t == WT) begin
      m_left--;
      x.last = (m_left == 0);
      model_put(x, x.last);
      if (x.last) begin m_in_burst = 0; m_per_beat = 0; end
    end else begin
      m_err = 1;
      x.last = 1'b1;
      model_put(x, 1);
      m_in_burst = 0; m_per_beat = 0;
    end
  endfunction

  function automatic int m_count();
    return exp_q.size() + pend_q.size();
  endfunction

  task automatic check_all();
    beat_t head;
    head = {io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt, io_pop_wt_data, io_pop_wt_mask, io_pop_last};
    check_eq("push_ready", io_push_ready, m_count() < DEPTH);
    check_eq("pop_valid", io_pop_valid, exp_q.size() != 0);
    check_eq("level", level, m_count());
    check_eq("almost_full", almost_full, m_count() >= DEPTH - 2);
    check_eq("burst_pending", burst_pending, m_in_burst);
    check_eq("err_burst", err_burst, m_err);
    if (exp_q.size() != 0) check_eq("head", head, exp_q[0]);
  endtask

  // driver: present one cycle of inputs, advance the model at the edge, check at negedge
  task automatic step(input bit pv, input beat_t x, input bit pr);
    bit acc, popf;
    io_push_valid = pv;
    io_push_cmd_type = x.t; io_push_addr = x.a; io_push_burst_cnt = x.b;
    io_push_wt_data = x.d; io_push_wt_mask = x.m;
    io_pop_ready = pr;
    acc  = pv && (m_count() < DEPTH);
    popf = pr && (exp_q.size() != 0);
    @(posedge clk);
    if (popf) void'(exp_q.pop_front());
    if (acc && x.t != IDE) model_store(x);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit pr);
    step(1'b0, mk(IDE, '0, '0, '0, '0), pr);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && m_count() > 0; i++) idle(1'b1);
    check_eq("drained", level, 0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_push_ready", io_push_ready, 0);
    check_eq("rst_pop_valid", io_pop_valid, 0);
    check_eq("rst_pop_last", io_pop_last, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_almost_full", almost_full, 0);
    check_eq("rst_burst_pending", burst_pending, 0);
    check_eq("rst_err_burst", err_burst, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    io_push_valid = 1'b0;
    io_pop_ready = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();
  endtask

  logic [127:0] base;
  beat_t rb;

  initial begin
    base = 128'h0123456789abcdeffedcba9876543210;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    // single RD: visible next cycle, then popped
    step(1'b1, mk(RD, 27'h100, 6'd0, '0, '0), 1'b0);
    check_eq("rd_last", io_pop_last, 1);
    idle(1'b1);

    // 8-beat packet write with the consumer always ready
    for (int i = 0; i < 8; i++)
      step(1'b1, mk(WT, 27'h200 + 27'(i), 6'd7, base + 128'(i), 16'h0001 << i), 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // fill to full, then push+pop together while full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(WT, 27'(i), 6'd0, 128'(i), 16'hffff), 1'b0);
    check_eq("full_ready", io_push_ready, 0);
    step(1'b1, mk(WT, 27'h7ff, 6'd0, '1, '1), 1'b1);
    check_eq("full_pp_level", level, DEPTH - 1);
    drain();

    // burst cut short by a CMD
    do_reset();
    step(1'b1, mk(WT, 27'h300, 6'd3, 128'hA0, 16'h1), 1'b0);
    step(1'b1, mk(WT, 27'h301, 6'd3, 128'hA1, 16'h2), 1'b0);
    step(1'b1, mk(CMD, 27'h302, 6'd0, 128'h0, 16'h0), 1'b0);
    check_eq("interrupt_err", err_burst, 1);
    drain();

    // oversize burst releases beat by beat
    do_reset();
    for (int i = 0; i < 32; i++)
      step(1'b1, mk(WT, 27'h400 + 27'(i), 6'd31, base ^ 128'(i), 16'(i)), 1'b1);
    check_eq("oversize_err", err_burst, 1);
    drain();

    // reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, mk(WT, 27'h500 + 27'(i), 6'd7, 128'(i), 16'h3), 1'b0);
    do_reset();
    step(1'b1, mk(RD, 27'h600, 6'd2, '0, '0), 1'b0);
    idle(1'b1);

    // random traffic in segments
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        int sel;
        sel = $urandom_range(0, 9);
        if (m_in_burst && $urandom_range(0, 19) != 0) sel = 9;
        rb = mk(sel == 0 ? IDE : sel < 3 ? CMD : sel < 5 ? RD : WT,
                27'($urandom()),
                ($urandom_range(0, 9) == 0) ? 6'($urandom_range(15, 20)) : 6'($urandom_range(0, 4)),
                {$urandom(), $urandom(), $urandom(), $urandom()},
                16'($urandom()));
        step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < 80 && m_in_burst; c++)
        step(1'b1, mk(WT, 27'($urandom()), 6'd0, {4{$urandom()}}, 16'($urandom())), 1'b1);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
